// File: rtl/pong_match_ctrl_if.sv
// Interface for the match sequencer: debounced button, frame and point pulses in;
// ball-engine gating and match status out.
interface pong_match_ctrl_if #(
  parameter int unsigned SCORE_W = 2
);
  logic               start_btn;
  logic               pause_btn;
  logic               frame_end;
  logic               point_p1;
  logic               point_p2;
  logic               ball_enable;
  logic               ball_recenter;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  modport master (
    output start_btn, pause_btn, frame_end, point_p1, point_p2,
    input  ball_enable, ball_recenter, serve_dir, score_p1, score_p2, winner, state_o
  );

  modport slave (
    input  start_btn, pause_btn, frame_end, point_p1, point_p2,
    output ball_enable, ball_recenter, serve_dir, score_p1, score_p2, winner, state_o
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/point frame-counted pauses, scores, pause and game over.
// Optional macro PONG_WIN_BY_TWO_EN: match ends only on a >=2 lead past WIN_SCORE, or at saturation.
module pong_match_ctrl #(
  parameter int unsigned SCORE_W      = 2,
  parameter int unsigned WIN_SCORE    = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic              clk_in,
  input  logic              i_rst_n,
  pong_match_ctrl_if.slave  bus
);
  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES) + 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W+1:0] WIN_X      = (SCORE_W+2)'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    PAUSED = 3'd4,
    OVER   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0]         win_q, win_d;
  logic               en_q, en_d, rc_q, rc_d, dir_q, dir_d;

  logic start, pause, frame, p1_only, p2_only, any_pt;
  logic serve_done, hold_done, restart, p1_wins, p2_wins;
  logic [SCORE_W+1:0] w1, w2;

  assign start      = bus.start_btn;
  assign pause      = bus.pause_btn;
  assign frame      = bus.frame_end;
  assign p1_only    = bus.point_p1 & ~bus.point_p2;
  assign p2_only    = bus.point_p2 & ~bus.point_p1;
  assign any_pt     = bus.point_p1 | bus.point_p2;
  assign serve_done = frame && (cnt_q == SERVE_LAST);
  assign hold_done  = frame && (cnt_q == POINT_LAST);
  assign restart    = start && (state_q inside {IDLE, PAUSED, OVER});
  assign w1         = {2'b00, s1_q};
  assign w2         = {2'b00, s2_q};

`ifdef PONG_WIN_BY_TWO_EN
  assign p1_wins = (s1_q == SCORE_MAX) || ((w1 >= WIN_X) && (w1 >= w2 + 2'd2));
  assign p2_wins = (s2_q == SCORE_MAX) || ((w2 >= WIN_X) && (w2 >= w1 + 2'd2));
`else
  assign p1_wins = (w1 == WIN_X);
  assign p2_wins = (w2 == WIN_X);
`endif

  // State register
  always_ff @(posedge clk_in or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start)              state_d = SERVE;
      SERVE:  if (serve_done)         state_d = PLAY;
      PLAY:   if (any_pt)             state_d = POINT;
              else if (pause)         state_d = PAUSED;
      POINT:  if (p1_wins || p2_wins) state_d = OVER;
              else if (hold_done)     state_d = SERVE;
      PAUSED: if (start)              state_d = SERVE;
              else if (pause)         state_d = PLAY;
      OVER:   if (start)              state_d = SERVE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output / datapath next values; the enable tracks the state being entered so it is registered.
  always_comb begin
    cnt_d = cnt_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    win_d = win_q;
    dir_d = dir_q;
    rc_d  = 1'b0;
    en_d  = (state_d == PLAY);
    if (restart) begin
      s1_d  = '0;
      s2_d  = '0;
      win_d = 2'b00;
      cnt_d = '0;
      rc_d  = 1'b1;
    end else begin
      unique case (state_q)
        SERVE: if (frame) cnt_d = serve_done ? '0 : cnt_q + 1'b1;
        PLAY: if (any_pt) begin
          cnt_d = '0;
          if (p1_only) begin
            s1_d  = (s1_q == SCORE_MAX) ? s1_q : s1_q + 1'b1;
            dir_d = 1'b0;
          end else if (p2_only) begin
            s2_d  = (s2_q == SCORE_MAX) ? s2_q : s2_q + 1'b1;
            dir_d = 1'b1;
          end
        end
        POINT: begin
          if (p1_wins)      win_d = 2'b01;
          else if (p2_wins) win_d = 2'b10;
          else if (frame) begin
            cnt_d = hold_done ? '0 : cnt_q + 1'b1;
            rc_d  = hold_done;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      win_q <= 2'b00;
      en_q  <= 1'b0;
      rc_q  <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      win_q <= win_d;
      en_q  <= en_d;
      rc_q  <= rc_d;
      dir_q <= dir_d;
    end
  end

  assign bus.ball_enable   = en_q;
  assign bus.ball_recenter = rc_q;
  assign bus.serve_dir     = dir_q;
  assign bus.score_p1      = s1_q;
  assign bus.score_p2      = s2_q;
  assign bus.winner        = win_q;
  assign bus.state_o       = state_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed table-driven bench for pong_match_ctrl (default parameters, default build).
module tb_pong_match_ctrl;
  logic clk_in = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk_in = ~clk_in;

  pong_match_ctrl_if #(.SCORE_W(2)) bus ();

  pong_match_ctrl #(
    .SCORE_W(2), .WIN_SCORE(3), .SERVE_FRAMES(60), .POINT_FRAMES(30)
  ) dut (
    .clk_in (clk_in),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  // in = {start, pause, frame, p1, p2}; inputs repeated rep times with idle cycles between
  typedef struct {
    logic [4:0] in;
    int         rep;
    logic       en, rc, dir;
    logic [1:0] s1, s2, win;
    logic [2:0] st;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [4:0] in, int rep, logic en, logic rc, logic dir,
                              logic [1:0] s1, logic [1:0] s2, logic [1:0] win, logic [2:0] st);
    vec_t v;
    v.in = in; v.rep = rep; v.en = en; v.rc = rc; v.dir = dir;
    v.s1 = s1; v.s2 = s2; v.win = win; v.st = st;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(logic [4:0] in);
    {bus.start_btn, bus.pause_btn, bus.frame_end, bus.point_p1, bus.point_p2} = in;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all(string tag, logic en, logic rc, logic dir,
                           logic [1:0] s1, logic [1:0] s2, logic [1:0] win, logic [2:0] st);
    check({tag, ".state"},   int'(bus.state_o),       int'(st));
    check({tag, ".enable"},  int'(bus.ball_enable),   int'(en));
    check({tag, ".recent"},  int'(bus.ball_recenter), int'(rc));
    check({tag, ".dir"},     int'(bus.serve_dir),     int'(dir));
    check({tag, ".s1"},      int'(bus.score_p1),      int'(s1));
    check({tag, ".s2"},      int'(bus.score_p2),      int'(s2));
    check({tag, ".winner"},  int'(bus.winner),        int'(win));
  endtask

  initial begin
    // start pause frame p1 p2 encodings
    vt.push_back(mk(5'b10000,   1, 0,1,0, 0,0,0, 1)); // start -> SERVE, recenter pulse
    vt.push_back(mk(5'b00000,   1, 0,0,0, 0,0,0, 1)); // recenter is one cycle
    vt.push_back(mk(5'b01000,   1, 0,0,0, 0,0,0, 1)); // pause ignored in SERVE
    vt.push_back(mk(5'b00010,   1, 0,0,0, 0,0,0, 1)); // point ignored in SERVE
    vt.push_back(mk(5'b10000,   1, 0,0,0, 0,0,0, 1)); // start ignored in SERVE
    vt.push_back(mk(5'b00100,  59, 0,0,0, 0,0,0, 1)); // 59 frames: still serving
    vt.push_back(mk(5'b00100,   1, 1,0,0, 0,0,0, 2)); // 60th frame -> PLAY
    vt.push_back(mk(5'b00000,   1, 1,0,0, 0,0,0, 2));
    vt.push_back(mk(5'b10000,   1, 1,0,0, 0,0,0, 2)); // start ignored in PLAY
    vt.push_back(mk(5'b00010,   1, 0,0,0, 1,0,0, 3)); // P1 point
    vt.push_back(mk(5'b00100,  29, 0,0,0, 1,0,0, 3));
    vt.push_back(mk(5'b00100,   1, 0,1,0, 1,0,0, 1)); // 30th frame -> recenter, SERVE
    vt.push_back(mk(5'b00000,   1, 0,0,0, 1,0,0, 1));
    vt.push_back(mk(5'b00100,  60, 1,0,0, 1,0,0, 2));
    vt.push_back(mk(5'b00001,   1, 0,0,1, 1,1,0, 3)); // P2 point, serve left
    vt.push_back(mk(5'b00010,   1, 0,0,1, 1,1,0, 3)); // point ignored in POINT
    vt.push_back(mk(5'b11000,   1, 0,0,1, 1,1,0, 3)); // start/pause ignored in POINT
    vt.push_back(mk(5'b00100,  30, 0,1,1, 1,1,0, 1));
    vt.push_back(mk(5'b00100,  60, 1,0,1, 1,1,0, 2));
    vt.push_back(mk(5'b01000,   1, 0,0,1, 1,1,0, 4)); // pause
    vt.push_back(mk(5'b00100, 100, 0,0,1, 1,1,0, 4)); // frames while paused
    vt.push_back(mk(5'b00010,   1, 0,0,1, 1,1,0, 4)); // point ignored while paused
    vt.push_back(mk(5'b01000,   1, 1,0,1, 1,1,0, 2)); // unpause
    vt.push_back(mk(5'b00011,   1, 0,0,1, 1,1,0, 3)); // simultaneous points
    vt.push_back(mk(5'b00100,  30, 0,1,1, 1,1,0, 1));
    vt.push_back(mk(5'b00100,  60, 1,0,1, 1,1,0, 2));
    vt.push_back(mk(5'b01010,   1, 0,0,0, 2,1,0, 3)); // point beats pause
    vt.push_back(mk(5'b00100,  30, 0,1,0, 2,1,0, 1));
    vt.push_back(mk(5'b00100,  60, 1,0,0, 2,1,0, 2));
    vt.push_back(mk(5'b00001,   1, 0,0,1, 2,2,0, 3));
    vt.push_back(mk(5'b00100,  30, 0,1,1, 2,2,0, 1));
    vt.push_back(mk(5'b00100,  60, 1,0,1, 2,2,0, 2));
    vt.push_back(mk(5'b00001,   1, 0,0,1, 2,3,0, 3)); // P2 reaches 3
    vt.push_back(mk(5'b00000,   1, 0,0,1, 2,3,2, 5)); // OVER with no hold
    vt.push_back(mk(5'b00100,   5, 0,0,1, 2,3,2, 5));
    vt.push_back(mk(5'b00010,   1, 0,0,1, 2,3,2, 5));
    vt.push_back(mk(5'b01000,   1, 0,0,1, 2,3,2, 5)); // pause ignored in OVER
    vt.push_back(mk(5'b10000,   1, 0,1,1, 0,0,0, 1)); // restart
    vt.push_back(mk(5'b00100,  60, 1,0,1, 0,0,0, 2));
    vt.push_back(mk(5'b00010,   1, 0,0,0, 1,0,0, 3)); // into POINT for reset test

    drive(5'b00000);
    i_rst_n = 1'b0;
    #12;
    check_all("reset", 0,0,0, 0,0,0, 0);
    i_rst_n = 1'b1;
    tick();
    check_all("idle", 0,0,0, 0,0,0, 0);

    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].rep; k++) begin
        if (k > 0) begin
          drive(5'b00000);
          tick();
        end
        drive(vt[i].in);
        tick();
      end
      drive(5'b00000);
      check_all($sformatf("v%0d", i), vt[i].en, vt[i].rc, vt[i].dir,
                vt[i].s1, vt[i].s2, vt[i].win, vt[i].st);
    end

    // Async reset mid-POINT, asserted away from any clock edge
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all("rst_mid", 0,0,0, 0,0,0, 0);
    #3;
    i_rst_n = 1'b1;
    tick();
    check_all("rst_rel", 0,0,0, 0,0,0, 0);
    drive(5'b10000);
    tick();
    drive(5'b00000);
    check_all("post_rst", 0,1,0, 0,0,0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
